// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: operation codes and
// the counter-width helper used by the top, the interface and the counter.
package shift_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_ASR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_LOAD  = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  function automatic int cnt_width(int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register; the master drives the
// operation, the slave (the register) returns contents, count and done.
interface univ_shift_reg_if #(
    parameter int WIDTH = 6
);

    logic                                      en;
    logic [2:0]                                mode;
    logic                                      sin_l;
    logic                                      sin_r;
    logic [WIDTH-1:0]                          pdata;
    logic [WIDTH-1:0]                          q;
    logic                                      sout_l;
    logic                                      sout_r;
    logic [shift_pkg::cnt_width(WIDTH)-1:0]    cnt;
    logic                                      done;

    modport master (
        output en, mode, sin_l, sin_r, pdata,
        input  q, sout_l, sout_r, cnt, done
    );

    modport slave (
        input  en, mode, sin_l, sin_r, pdata,
        output q, sout_l, sout_r, cnt, done
    );

endinterface

// File: rtl/shift_cnt.sv
// Saturating shift counter with a registered one-cycle done pulse fired on
// the edge where the count first reaches WIDTH.
module shift_cnt
    import shift_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          inc,
    input  logic                          restart,
    output logic [cnt_width(WIDTH)-1:0]   cnt,
    output logic                          done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [CW-1:0] cnt_r;
    logic          done_r;

    // restart outranks inc so a load/clear on the completing edge suppresses done
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else if (restart) begin
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r  <= cnt_r + CW'(1);
            done_r <= (cnt_r == CNT_MAX - CW'(1));
        end else begin
            done_r <= 1'b0;
        end
    end

    assign cnt  = cnt_r;
    assign done = done_r;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: shift/rotate/arithmetic modes, parallel load and
// clear, with a saturating shift counter for serialiser/deserialiser use.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int               WIDTH     = 6,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    clr,
    univ_shift_reg_if.slave         bus
);

    if (WIDTH < 2) begin : g_width_check
        $error("univ_shift_reg: WIDTH must be >= 2");
    end

    logic [WIDTH-1:0] q_r;
    logic             is_shift;
    logic             is_restart;

    always_comb begin
        is_shift   = 1'b0;
        is_restart = 1'b0;
        case (bus.mode)
            MODE_SHL, MODE_SHR, MODE_ASR, MODE_ROL, MODE_ROR: is_shift = bus.en;
            MODE_LOAD, MODE_CLEAR:                            is_restart = bus.en;
            default: ;
        endcase
    end

    // unknown or HOLD mode falls through to the default and keeps q
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_r <= RESET_VAL;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_SHL:   q_r <= {q_r[WIDTH-2:0], bus.sin_l};
                MODE_SHR:   q_r <= {bus.sin_r, q_r[WIDTH-1:1]};
                MODE_ASR:   q_r <= {q_r[WIDTH-1], q_r[WIDTH-1:1]};
                MODE_ROL:   q_r <= {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                MODE_ROR:   q_r <= {q_r[0], q_r[WIDTH-1:1]};
                MODE_LOAD:  q_r <= bus.pdata;
                MODE_CLEAR: q_r <= '0;
                default:    q_r <= q_r;
            endcase
        end
    end

    shift_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk     (clk),
        .clr     (clr),
        .inc     (is_shift),
        .restart (is_restart),
        .cnt     (bus.cnt),
        .done    (bus.done)
    );

    assign bus.q      = q_r;
    assign bus.sout_l = q_r[WIDTH-1];
    assign bus.sout_r = q_r[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=6: reset, rotates, arithmetic
// shifts, serialiser count/done, enable/hold and load-vs-count collision.
module tb_univ_shift_reg;
    import shift_pkg::*;

    logic clk;
    logic clr;
    int   n_tests;
    int   n_fail;

    univ_shift_reg_if #(.WIDTH(6)) bus ();

    univ_shift_reg #(.WIDTH(6), .RESET_VAL(6'b000000)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drive one operation, then sample 1 time unit after the edge
    task automatic op(input logic en, input logic [2:0] mode, input logic [5:0] pdata,
                      input logic sl, input logic sr);
        bus.en    = en;
        bus.mode  = mode;
        bus.pdata = pdata;
        bus.sin_l = sl;
        bus.sin_r = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        clr = 1'b0;
        op(1'b0, MODE_HOLD, 6'd0, 1'b0, 1'b0);
        n_tests++;
        if ({bus.q, bus.cnt, bus.done} !== {6'b000000, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_init q=%b cnt=%0d done=%b, want q=000000 cnt=0 done=0", bus.q, bus.cnt, bus.done);
        end
        clr = 1'b1;
        op(1'b1, MODE_LOAD, 6'b101101, 1'b0, 1'b0);
        op(1'b1, MODE_ROL, 6'd0, 1'b0, 1'b0);
        n_tests++;
        if ({bus.q, bus.cnt} !== {6'b011011, 3'd1}) begin
            n_fail++;
            $display("FAIL reset_pre q=%b cnt=%0d, want q=011011 cnt=1", bus.q, bus.cnt);
        end
        op(1'b1, MODE_ROR, 6'd0, 1'b0, 1'b0);
        #2 clr = 1'b0;
        #1;
        n_tests++;
        if ({bus.q, bus.cnt, bus.done} !== {6'b000000, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async q=%b cnt=%0d done=%b, want q=000000 cnt=0 done=0", bus.q, bus.cnt, bus.done);
        end
        #1 clr = 1'b1;
        op(1'b1, MODE_LOAD, 6'b110011, 1'b0, 1'b0);
        n_tests++;
        if ({bus.q, bus.cnt, bus.done} !== {6'b110011, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release_load q=%b cnt=%0d done=%b, want q=110011 cnt=0 done=0", bus.q, bus.cnt, bus.done);
        end
    endtask

    task automatic test_rotate;
        op(1'b1, MODE_LOAD, 6'b101101, 1'b0, 1'b0);
        n_tests++;
        if ({bus.q, bus.cnt} !== {6'b101101, 3'd0}) begin
            n_fail++;
            $display("FAIL rot_load q=%b cnt=%0d, want q=101101 cnt=0", bus.q, bus.cnt);
        end
        op(1'b1, MODE_ROL, 6'd0, 1'b0, 1'b0);
        n_tests++;
        if ({bus.q, bus.cnt} !== {6'b011011, 3'd1}) begin
            n_fail++;
            $display("FAIL rol q=%b cnt=%0d, want q=011011 cnt=1", bus.q, bus.cnt);
        end
        op(1'b1, MODE_ROR, 6'd0, 1'b0, 1'b0);
        n_tests++;
        if ({bus.q, bus.cnt, bus.sout_l, bus.sout_r} !== {6'b101101, 3'd2, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL ror q=%b cnt=%0d sout_l=%b sout_r=%b, want q=101101 cnt=2 sout_l=1 sout_r=1",
                     bus.q, bus.cnt, bus.sout_l, bus.sout_r);
        end
    endtask

    task automatic test_arith;
        op(1'b1, MODE_LOAD, 6'b100000, 1'b0, 1'b0);
        op(1'b1, MODE_ASR, 6'd0, 1'b0, 1'b0);
        n_tests++;
        if (bus.q !== 6'b110000) begin
            n_fail++;
            $display("FAIL asr1 q=%b, want 110000", bus.q);
        end
        op(1'b1, MODE_ASR, 6'd0, 1'b0, 1'b1);
        n_tests++;
        if ({bus.q, bus.cnt} !== {6'b111000, 3'd2}) begin
            n_fail++;
            $display("FAIL asr2 q=%b cnt=%0d, want q=111000 cnt=2", bus.q, bus.cnt);
        end
        op(1'b1, MODE_LOAD, 6'b100000, 1'b0, 1'b0);
        op(1'b1, MODE_SHR, 6'd0, 1'b1, 1'b0);
        n_tests++;
        if (bus.q !== 6'b010000) begin
            n_fail++;
            $display("FAIL shr q=%b, want 010000", bus.q);
        end
        op(1'b1, MODE_SHR, 6'd0, 1'b0, 1'b1);
        n_tests++;
        if (bus.q !== 6'b101000) begin
            n_fail++;
            $display("FAIL shr_sin q=%b, want 101000", bus.q);
        end
    endtask

    task automatic test_serialiser;
        logic [5:0] exp_q;
        op(1'b1, MODE_CLEAR, 6'd0, 1'b0, 1'b0);
        exp_q = 6'b000001;
        for (int i = 1; i <= 6; i++) begin
            op(1'b1, MODE_SHL, 6'd0, (i == 1), 1'b0);
            n_tests++;
            if ({bus.q, bus.cnt, bus.done, bus.sout_l} !== {exp_q, 3'(i), (i == 6), exp_q[5]}) begin
                n_fail++;
                $display("FAIL ser_step%0d q=%b cnt=%0d done=%b sout_l=%b, want q=%b cnt=%0d done=%b",
                         i, bus.q, bus.cnt, bus.done, bus.sout_l, exp_q, i, (i == 6));
            end
            exp_q = exp_q << 1;
        end
        op(1'b1, MODE_SHL, 6'd0, 1'b0, 1'b0);
        n_tests++;
        if ({bus.q, bus.cnt, bus.done} !== {6'b000000, 3'd6, 1'b0}) begin
            n_fail++;
            $display("FAIL ser_sat q=%b cnt=%0d done=%b, want q=000000 cnt=6 done=0", bus.q, bus.cnt, bus.done);
        end
    endtask

    task automatic test_enable_hold;
        op(1'b1, MODE_LOAD, 6'b010101, 1'b0, 1'b0);
        op(1'b1, MODE_ROL, 6'd0, 1'b0, 1'b0);
        op(1'b1, MODE_ROR, 6'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            op(1'b0, MODE_SHL, 6'd0, 1'b1, 1'b1);
            n_tests++;
            if ({bus.q, bus.cnt, bus.done} !== {6'b010101, 3'd2, 1'b0}) begin
                n_fail++;
                $display("FAIL en_off%0d q=%b cnt=%0d done=%b, want q=010101 cnt=2 done=0",
                         i, bus.q, bus.cnt, bus.done);
            end
        end
        op(1'b1, MODE_HOLD, 6'b111111, 1'b1, 1'b1);
        n_tests++;
        if ({bus.q, bus.cnt, bus.done} !== {6'b010101, 3'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL hold q=%b cnt=%0d done=%b, want q=010101 cnt=2 done=0", bus.q, bus.cnt, bus.done);
        end
        op(1'b1, MODE_CLEAR, 6'b111111, 1'b1, 1'b1);
        n_tests++;
        if ({bus.q, bus.cnt, bus.done} !== {6'b000000, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL clear q=%b cnt=%0d done=%b, want q=000000 cnt=0 done=0", bus.q, bus.cnt, bus.done);
        end
    endtask

    task automatic test_collision;
        op(1'b1, MODE_LOAD, 6'b000111, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) op(1'b1, MODE_ROL, 6'd0, 1'b0, 1'b0);
        n_tests++;
        if ({bus.q, bus.cnt} !== {6'b100011, 3'd5}) begin
            n_fail++;
            $display("FAIL coll_pre q=%b cnt=%0d, want q=100011 cnt=5", bus.q, bus.cnt);
        end
        op(1'b1, MODE_LOAD, 6'b111000, 1'b0, 1'b0);
        n_tests++;
        if ({bus.q, bus.cnt, bus.done} !== {6'b111000, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL coll_load q=%b cnt=%0d done=%b, want q=111000 cnt=0 done=0", bus.q, bus.cnt, bus.done);
        end
        for (int i = 1; i <= 6; i++) begin
            op(1'b1, MODE_ROR, 6'd0, 1'b0, 1'b0);
            n_tests++;
            if ({bus.cnt, bus.done} !== {3'(i), (i == 6)}) begin
                n_fail++;
                $display("FAIL coll_ror%0d cnt=%0d done=%b, want cnt=%0d done=%b",
                         i, bus.cnt, bus.done, i, (i == 6));
            end
        end
        n_tests++;
        if (bus.q !== 6'b111000) begin
            n_fail++;
            $display("FAIL coll_ror_q q=%b, want 111000", bus.q);
        end
        op(1'b0, MODE_ROR, 6'd0, 1'b0, 1'b0);
        n_tests++;
        if ({bus.q, bus.cnt, bus.done} !== {6'b111000, 3'd6, 1'b0}) begin
            n_fail++;
            $display("FAIL done_drop q=%b cnt=%0d done=%b, want q=111000 cnt=6 done=0", bus.q, bus.cnt, bus.done);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clr       = 1'b0;
        bus.en    = 1'b0;
        bus.mode  = MODE_HOLD;
        bus.pdata = '0;
        bus.sin_l = 1'b0;
        bus.sin_r = 1'b0;
        #2;
        test_reset();
        test_rotate();
        test_arith();
        test_serialiser();
        test_enable_hold();
        test_collision();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
